// File: rtl/mp3_stream_ctrl.sv
// MP3 decoder stream controller: holds XRST, sends the SCI init commands, then streams song words over SDI.
// Optional volume SCI writes are enabled by defining MP3_VOL_CTRL_EN.
module mp3_stream_ctrl #(
  parameter int                    CMD_NUM    = 2,
  parameter logic [CMD_NUM*32-1:0] CMD_ROM    = {32'h02000804, 32'h020B0000},
  parameter int                    DATA_W     = 16,
  parameter int                    NUM_SONGS  = 4,
  parameter int                    SONG_LEN   = 16384,
  parameter int                    ADDR_W     = 16,
  parameter int                    DELAY_TIME = 500000,
  localparam int                   SEL_W      = (NUM_SONGS > 1) ? $clog2(NUM_SONGS) : 1
) (
  input  logic              mp3_clk,
  input  logic              rst_n,
  input  logic              i_DREQ,
  input  logic [SEL_W-1:0]  song_sel,
  input  logic [7:0]        vol,
  input  logic              vol_wr,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic              o_XRST,
  output logic              o_XCS,
  output logic              o_XDCS,
  output logic              o_SI,
  output logic              o_SCK,
  output logic              o_busy,
  output logic              o_song_done
);

  localparam int DLY_W = (DELAY_TIME > 1) ? $clog2(DELAY_TIME + 1) : 1;

  typedef enum logic [2:0] {
    HOLD, CMD_PRE, CMD_SHIFT, DATA_PRE, DATA_FETCH, DATA_SHIFT
`ifdef MP3_VOL_CTRL_EN
    , VOL_SHIFT
`endif
  } state_t;

  state_t             r_state, w_next;
  logic [DLY_W-1:0]   r_dly;
  logic [2:0]         r_cmd_idx;
  logic [ADDR_W-1:0]  r_off;
  logic [SEL_W-1:0]   r_cur_sel;
  logic [31:0]        r_sr;
  logic [4:0]         r_bit, r_len;
  logic               r_phase;
  logic               r_xrst, r_xcs, r_xdcs, r_si, r_sck, r_done;

  logic [31:0]        w_cmd_word, w_data_word, w_load_word;
  logic [4:0]         w_load_len;
  logic               w_load, w_last, w_shifting, w_sel_chg, w_dly_done;

`ifdef MP3_VOL_CTRL_EN
  logic [7:0]         r_vol;
  logic               r_vol_pend;
`else
  logic               w_unused_vol;
  assign w_unused_vol = ^{vol, vol_wr};
`endif

  always_comb begin
    w_cmd_word = 32'h0;
    for (int i = 0; i < CMD_NUM; i++)
      if (r_cmd_idx == 3'(i)) w_cmd_word = CMD_ROM[(CMD_NUM-1-i)*32 +: 32];
  end

  // Data words are left-aligned so every frame shifts out of bit 31.
  assign w_data_word = 32'(mem_data) << (32 - DATA_W);
  assign w_last      = r_phase && (r_bit == r_len);
  assign w_sel_chg   = (song_sel != r_cur_sel);
  assign w_dly_done  = (r_dly == DLY_W'(DELAY_TIME - 1));
  assign w_shifting  = (r_state == CMD_SHIFT) || (r_state == DATA_SHIFT)
`ifdef MP3_VOL_CTRL_EN
                    || (r_state == VOL_SHIFT)
`endif
                     ;

  always_comb begin
    w_next = r_state;
    case (r_state)
      HOLD:       if (w_dly_done) w_next = CMD_PRE;
      CMD_PRE:    if (r_cmd_idx == 3'(CMD_NUM)) w_next = DATA_PRE;
                  else if (i_DREQ)               w_next = CMD_SHIFT;
      CMD_SHIFT:  if (w_last) w_next = CMD_PRE;
      // A song switch spends one cycle here so mem_addr settles before the fetch.
      DATA_PRE:   if (!w_sel_chg) begin
`ifdef MP3_VOL_CTRL_EN
                    if (r_vol_pend && i_DREQ) w_next = VOL_SHIFT; else
`endif
                    if (i_DREQ) w_next = DATA_FETCH;
                  end
      DATA_FETCH: w_next = DATA_SHIFT;
      DATA_SHIFT: if (w_last) w_next = DATA_PRE;
`ifdef MP3_VOL_CTRL_EN
      VOL_SHIFT:  if (w_last) w_next = DATA_PRE;
`endif
      default:    w_next = HOLD;
    endcase
  end

  always_comb begin
    w_load      = 1'b0;
    w_load_word = w_cmd_word;
    w_load_len  = 5'd31;
    if (r_state == CMD_PRE && w_next == CMD_SHIFT) w_load = 1'b1;
    if (r_state == DATA_FETCH) begin
      w_load      = 1'b1;
      w_load_word = w_data_word;
      w_load_len  = 5'(DATA_W - 1);
    end
`ifdef MP3_VOL_CTRL_EN
    if (r_state == DATA_PRE && w_next == VOL_SHIFT) begin
      w_load      = 1'b1;
      w_load_word = {16'h020B, r_vol, r_vol};
    end
`endif
  end

  always_ff @(posedge mp3_clk) begin
    if (!rst_n) begin
      r_state   <= HOLD;
      r_dly     <= '0;
      r_cmd_idx <= '0;
      r_off     <= '0;
      r_cur_sel <= '0;
      r_sr      <= '0;
      r_bit     <= '0;
      r_len     <= '0;
      r_phase   <= 1'b0;
      r_xrst    <= 1'b0;
      r_xcs     <= 1'b1;
      r_xdcs    <= 1'b1;
      r_si      <= 1'b0;
      r_sck     <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= 1'b0;

      if (r_state == HOLD) begin
        if (w_dly_done) r_xrst <= 1'b1;
        else            r_dly  <= r_dly + DLY_W'(1);
      end

      if (r_state == DATA_PRE && w_sel_chg) begin
        r_cur_sel <= song_sel;
        r_off     <= '0;
      end

      // SI changes with the SCK fall; SCK is high for the second cycle of each bit.
      if (w_shifting) begin
        if (!r_phase) begin
          r_sck   <= 1'b1;
          r_phase <= 1'b1;
        end else begin
          r_sck   <= 1'b0;
          r_phase <= 1'b0;
          if (!w_last) begin
            r_si  <= r_sr[31];
            r_sr  <= r_sr << 1;
            r_bit <= r_bit + 5'd1;
          end
        end
      end

      if (w_last && r_state == CMD_SHIFT) begin
        r_xcs     <= 1'b1;
        r_cmd_idx <= r_cmd_idx + 3'd1;
      end
`ifdef MP3_VOL_CTRL_EN
      if (w_last && r_state == VOL_SHIFT) r_xcs <= 1'b1;
`endif
      if (w_last && r_state == DATA_SHIFT) begin
        r_xdcs <= 1'b1;
        if (r_off == ADDR_W'(SONG_LEN - 1)) begin
          r_off  <= '0;
          r_done <= 1'b1;
        end else begin
          r_off  <= r_off + ADDR_W'(1);
        end
      end

      if (w_load) begin
        r_sr    <= w_load_word << 1;
        r_si    <= w_load_word[31];
        r_bit   <= '0;
        r_len   <= w_load_len;
        r_phase <= 1'b0;
        r_sck   <= 1'b0;
        if (r_state == DATA_FETCH) r_xdcs <= 1'b0;
        else                       r_xcs  <= 1'b0;
      end
    end
  end

`ifdef MP3_VOL_CTRL_EN
  // A new vol_wr wins over the clear at the end of an in-flight volume write.
  always_ff @(posedge mp3_clk) begin
    if (!rst_n) begin
      r_vol      <= '0;
      r_vol_pend <= 1'b0;
    end else if (vol_wr) begin
      r_vol      <= vol;
      r_vol_pend <= 1'b1;
    end else if (r_state == VOL_SHIFT && w_last) begin
      r_vol_pend <= 1'b0;
    end
  end
`endif

  assign mem_addr    = ADDR_W'(r_cur_sel) * ADDR_W'(SONG_LEN) + r_off;
  assign o_XRST      = r_xrst;
  assign o_XCS       = r_xcs;
  assign o_XDCS      = r_xdcs;
  assign o_SI        = r_si;
  assign o_SCK       = r_sck;
  assign o_song_done = r_done;
  assign o_busy      = (r_state == DATA_PRE) || (r_state == DATA_FETCH) || (r_state == DATA_SHIFT)
`ifdef MP3_VOL_CTRL_EN
                    || (r_state == VOL_SHIFT)
`endif
                     ;

endmodule

// File: tb/tb_mp3_stream_ctrl.sv
// Directed bench for mp3_stream_ctrl: init command frames, song streaming, DREQ stall,
// song switch, volume write and mid-shift reset, decoded from the serial pins.
module tb_mp3_stream_ctrl;
  logic        mp3_clk = 1'b0, rst_n = 1'b0, i_DREQ = 1'b1, vol_wr = 1'b0;
  logic [1:0]  song_sel = 2'd2;
  logic [7:0]  vol = 8'h00;
  logic [15:0] mem_addr, mem_data;
  logic        o_XRST, o_XCS, o_XDCS, o_SI, o_SCK, o_busy, o_song_done;

  always #5 mp3_clk = ~mp3_clk;

  mp3_stream_ctrl #(.DATA_W(16), .NUM_SONGS(4), .SONG_LEN(4), .ADDR_W(16), .DELAY_TIME(10)) dut (
    .mp3_clk(mp3_clk), .rst_n(rst_n), .i_DREQ(i_DREQ), .song_sel(song_sel), .vol(vol), .vol_wr(vol_wr),
    .mem_addr(mem_addr), .mem_data(mem_data), .o_XRST(o_XRST), .o_XCS(o_XCS), .o_XDCS(o_XDCS),
    .o_SI(o_SI), .o_SCK(o_SCK), .o_busy(o_busy), .o_song_done(o_song_done));

  function automatic logic [15:0] memval(input logic [15:0] a);
    return (a == 16'd8) ? 16'hA5C3 : {a[7:0] ^ 8'h5A, a[7:0]};
  endfunction

  always @(posedge mp3_clk) mem_data <= memval(mem_addr);

  typedef struct {
    bit          is_data;
    logic [31:0] val;
    int          nbits;
    logic [15:0] addr;
  } frame_t;

  frame_t      frames[$];
  int          n_checks = 0, n_fail = 0;
  bit          p_sck = 0, p_xcs = 1, p_xdcs = 1, cur_is_data = 0, both_low = 0;
  int          cur_bits = 0, sck_rises = 0, done_cnt = 0;
  logic [31:0] cur_val = '0;
  logic [15:0] cur_addr = '0;

  // Frame decoder: one bit per SCK rise, a frame closes when its chip select rises.
  always begin
    @(posedge mp3_clk); #1;
    if (!rst_n) begin
      p_sck = 0; p_xcs = 1; p_xdcs = 1; cur_bits = 0; cur_val = '0;
    end else begin
      if (!o_XCS && !o_XDCS) both_low = 1;
      if (o_song_done) done_cnt++;
      if (o_SCK && !p_sck) begin
        if (cur_bits == 0) begin
          cur_is_data = !o_XDCS;
          cur_addr    = mem_addr;
        end
        cur_val = {cur_val[30:0], o_SI};
        cur_bits++;
        sck_rises++;
      end
      if ((o_XCS && !p_xcs) || (o_XDCS && !p_xdcs)) begin
        frames.push_back('{cur_is_data, cur_val, cur_bits, cur_addr});
        cur_bits = 0;
        cur_val  = '0;
      end
      p_sck = o_SCK; p_xcs = o_XCS; p_xdcs = o_XDCS;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_frames(input int n, input string name);
    int c = 0;
    while (frames.size() < n && c < 3000) begin
      @(negedge mp3_clk);
      c++;
    end
    chk({name, "_timeout"}, 32'(frames.size() >= n), 32'd1);
  endtask

  task automatic wait_xrst(input string name);
    int n = 0;
    do begin
      @(negedge mp3_clk);
      n++;
    end while (!o_XRST && n < 100);
    chk(name, 32'(n), 32'd10);
  endtask

  // Waits until the frame in flight (data or command) has shown nb SCK rises.
  task automatic wait_bit(input bit data, input int nb, input logic [15:0] addr, input bit use_addr,
                          input string name);
    int c = 0;
    while (c < 3000 && !((data ? !o_XDCS : !o_XCS) && cur_bits == nb && (!use_addr || cur_addr == addr))) begin
      @(negedge mp3_clk);
      c++;
    end
    chk({name, "_timeout"}, 32'(c < 3000), 32'd1);
  endtask

  function automatic logic [15:0] next_addr(input logic [15:0] a);
    return {a[15:2], a[1:0] + 2'd1};
  endfunction

  initial begin
    frame_t exp_tab[7];
    int     n0, d0, sr;
    exp_tab[0] = '{0, 32'h02000804, 32, 16'd0};
    exp_tab[1] = '{0, 32'h020B0000, 32, 16'd0};
    exp_tab[2] = '{1, 32'h0000A5C3, 16, 16'd8};
    exp_tab[3] = '{1, 32'(memval(16'd9)), 16, 16'd9};
    exp_tab[4] = '{1, 32'(memval(16'd10)), 16, 16'd10};
    exp_tab[5] = '{1, 32'(memval(16'd11)), 16, 16'd11};
    exp_tab[6] = '{1, 32'h0000A5C3, 16, 16'd8};

    // Reset state
    repeat (3) @(negedge mp3_clk);
    chk("rst_xrst", 32'(o_XRST), 0);
    chk("rst_xcs", 32'(o_XCS), 1);
    chk("rst_xdcs", 32'(o_XDCS), 1);
    chk("rst_sck", 32'(o_SCK), 0);
    chk("rst_si", 32'(o_SI), 0);
    chk("rst_busy", 32'(o_busy), 0);
    chk("rst_done", 32'(o_song_done), 0);

    // Init commands and first song pass
    rst_n = 1'b1;
    wait_xrst("xrst_delay");
    wait_frames(7, "init_stream");
    chk("song_done_once", 32'(done_cnt), 1);
    for (int i = 0; i < 7; i++) begin
      chk($sformatf("frame%0d_kind", i), 32'(frames[i].is_data), 32'(exp_tab[i].is_data));
      chk($sformatf("frame%0d_val", i), frames[i].val, exp_tab[i].val);
      chk($sformatf("frame%0d_bits", i), 32'(frames[i].nbits), 32'(exp_tab[i].nbits));
      if (exp_tab[i].is_data)
        chk($sformatf("frame%0d_addr", i), 32'(frames[i].addr), 32'(exp_tab[i].addr));
    end

    // DREQ drops at bit 5 of a data word
    wait_bit(1, 5, 16'd0, 0, "dreq_bit5");
    i_DREQ = 1'b0;
    n0 = frames.size();
    wait_frames(n0 + 1, "dreq_word");
    chk("dreq_word_bits", 32'(frames[n0].nbits), 16);
    chk("dreq_word_val", frames[n0].val, 32'(memval(frames[n0].addr)));
    sr = sck_rises;
    repeat (40) @(negedge mp3_clk);
    chk("stall_no_sck", 32'(sck_rises), 32'(sr));
    chk("stall_sck_low", 32'(o_SCK), 0);
    chk("stall_xdcs", 32'(o_XDCS), 1);
    chk("stall_busy", 32'(o_busy), 1);
    chk("stall_no_frame", 32'(frames.size()), 32'(n0 + 1));
    i_DREQ = 1'b1;
    wait_frames(n0 + 2, "resume");
    chk("resume_addr", 32'(frames[n0+1].addr), 32'(next_addr(frames[n0].addr)));

    // Song switch in the middle of word 9
    wait_bit(1, 3, 16'd9, 1, "sel_mid");
    song_sel = 2'd1;
    n0 = frames.size();
    d0 = done_cnt;
    wait_frames(n0 + 2, "sel_switch");
    chk("sel_inflight_addr", 32'(frames[n0].addr), 9);
    chk("sel_inflight_bits", 32'(frames[n0].nbits), 16);
    chk("sel_new_addr", 32'(frames[n0+1].addr), 4);
    chk("sel_new_val", frames[n0+1].val, 32'(memval(16'd4)));
    chk("sel_no_done", 32'(done_cnt), 32'(d0));

    // Volume write between two data words
    wait_bit(1, 2, 16'd0, 0, "vol_mid");
    vol = 8'h20;
    vol_wr = 1'b1;
    @(negedge mp3_clk);
    vol_wr = 1'b0;
    n0 = frames.size();
    wait_frames(n0 + 3, "vol_seq");
`ifdef MP3_VOL_CTRL_EN
    chk("vol_kind", 32'(frames[n0+1].is_data), 0);
    chk("vol_val", frames[n0+1].val, 32'h020B2020);
    chk("vol_bits", 32'(frames[n0+1].nbits), 32);
    chk("vol_after_kind", 32'(frames[n0+2].is_data), 1);
    chk("vol_after_addr", 32'(frames[n0+2].addr), 32'(next_addr(frames[n0].addr)));
`else
    chk("novol_kind1", 32'(frames[n0+1].is_data), 1);
    chk("novol_addr1", 32'(frames[n0+1].addr), 32'(next_addr(frames[n0].addr)));
    chk("novol_kind2", 32'(frames[n0+2].is_data), 1);
    chk("novol_addr2", 32'(frames[n0+2].addr), 32'(next_addr(frames[n0+1].addr)));
`endif

    // Reset at bit 7 of the first init command, then full restart
    rst_n = 1'b0;
    @(negedge mp3_clk);
    rst_n = 1'b1;
    wait_xrst("xrst_delay2");
    wait_bit(0, 7, 16'd0, 0, "cmd_bit7");
    rst_n = 1'b0;
    @(negedge mp3_clk);
    chk("midrst_xcs", 32'(o_XCS), 1);
    chk("midrst_sck", 32'(o_SCK), 0);
    chk("midrst_xrst", 32'(o_XRST), 0);
    chk("midrst_busy", 32'(o_busy), 0);
    rst_n = 1'b1;
    n0 = frames.size();
    wait_frames(n0 + 2, "restart");
    chk("restart_cmd0", frames[n0].val, 32'h02000804);
    chk("restart_cmd0_bits", 32'(frames[n0].nbits), 32);
    chk("restart_cmd1", frames[n0+1].val, 32'h020B0000);
    chk("restart_cmd1_kind", 32'(frames[n0+1].is_data), 0);

    chk("cs_exclusive", 32'(both_low), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
